// File: rtl/maxnet_pkg.sv
// Shared constants and types for the Maxnet front end.
// Loader state encodings and the activation slot type.
package maxnet_pkg;

    localparam int DEF_N      = 4;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        L_FILL  = 2'd0,
        L_START = 2'd1,
        L_WAIT  = 2'd2
    } lstate_e;

    typedef logic signed [DEF_DATA_W-1:0] slot_t;

endpackage

// File: rtl/maxnet_x_buffer.sv
// N-slot activation register file.
// Indexed write, synchronous clear, flat read vector.
module maxnet_x_buffer
    import maxnet_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = $clog2(N)
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clr,
    input  logic                i_we,
    input  logic [IDX_W-1:0]    i_idx,
    input  logic [DATA_W-1:0]   i_data,
    output logic [N*DATA_W-1:0] o_vec
);

    logic [DATA_W-1:0] r_mem [N];

    // Clear wins over write; the loader never asserts both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clr) begin
            for (int i = 0; i < N; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_idx] <= i_data;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign o_vec[g*DATA_W +: DATA_W] = r_mem[g];
    end

endmodule

// File: rtl/maxnet_input_loader.sv
// Stream-to-vector loader feeding the Maxnet controller.
// Fills N slots, pulses start, holds the vector until done.
module maxnet_input_loader
    import maxnet_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_last,
    output logic [N*DATA_W-1:0]     x_vec,
    output logic                    start,
    input  logic                    done,
    output logic                    busy,
    output logic [$clog2(N+1)-1:0]  count
);

    localparam int CNT_W = $clog2(N+1);
    localparam int IDX_W = $clog2(N);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N-1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    lstate_e          r_state;
    logic             r_in_ready;
    logic             r_start;
    logic             r_busy;
    logic [CNT_W-1:0] r_count;

    logic w_hs;
    logic w_close;
    logic w_release;

    // r_in_ready is high exactly when r_state is L_FILL.
    assign w_hs      = in_valid & r_in_ready;
    assign w_close   = w_hs & (in_last | (r_count == C_LAST));
    assign w_release = (r_state == L_WAIT) & done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= L_FILL;
            r_in_ready <= 1'b1;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                L_FILL: begin
                    if (w_hs) begin
                        r_count <= r_count + C_ONE;
                    end
                    if (w_close) begin
                        r_state    <= L_START;
                        r_in_ready <= 1'b0;
                        r_start    <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                L_START: begin
                    r_state <= L_WAIT;
                    r_start <= 1'b0;
                end
                L_WAIT: begin
                    if (done) begin
                        r_state    <= L_FILL;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_count    <= '0;
                    end
                end
                default: begin
                    r_state    <= L_FILL;
                    r_in_ready <= 1'b1;
                    r_start    <= 1'b0;
                    r_busy     <= 1'b0;
                    r_count    <= '0;
                end
            endcase
        end
    end

    maxnet_x_buffer #(
        .N      (N),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_buf (
        .clk    (clk),
        .rst_n  (rst),
        .i_clr  (w_release),
        .i_we   (w_hs),
        .i_idx  (r_count[IDX_W-1:0]),
        .i_data (in_data),
        .o_vec  (x_vec)
    );

    assign in_ready = r_in_ready;
    assign start    = r_start;
    assign busy     = r_busy;
    assign count    = r_count;

endmodule
